// File: rtl/frame_writer_pkg.sv
// frame_writer_pkg: frame geometry and writer state encodings shared with the scan-out reader
package frame_writer_pkg;
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;
  localparam int PIX_COUNT = SCR_W * SCR_H;
  localparam int ADDR_W = 15;
  localparam int COLOUR_W = 3;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
endpackage

// File: rtl/xy_to_addr.sv
// xy_to_addr: row-major pixel address (y*160+x) with range check on the raw 10-bit coordinates
import frame_writer_pkg::*;
module xy_to_addr (
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);
  assign addr = ADDR_W'({y, 7'b0}) + ADDR_W'({y, 5'b0}) + ADDR_W'(x);
  assign in_range = (x < 10'(SCR_W)) && (y < 10'(SCR_H));
endmodule

// File: rtl/frame_writer.sv
// frame_writer: drives the frame RAM write port from single-pixel plots and full-screen clears
import frame_writer_pkg::*;
module frame_writer (
  input  logic                clk,
  input  logic                reset,
  input  logic                plot,
  input  logic [9:0]          x,
  input  logic [9:0]          y,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                clear,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                ready,
  output logic                done,
  output logic                oob,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                mem_wren
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, addr_q, addr_d, pix_addr;
  logic [COLOUR_W-1:0] data_q, data_d;
  logic wren_q, wren_d, done_q, done_d, oob_q, oob_d, in_range, last;
  xy_to_addr u_xy (.x(x), .y(y), .addr(pix_addr), .in_range(in_range));
  assign ready = (state_q == IDLE);
  assign last = (cnt_q == ADDR_W'(PIX_COUNT - 1));
  // data_q keeps the fill colour for the whole clear since nothing else writes it meanwhile
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    data_d = data_q;
    wren_d = 1'b0;
    done_d = 1'b0;
    oob_d = 1'b0;
    if (state_q == CLEAR) begin
      state_d = last ? IDLE : CLEAR;
      cnt_d = last ? cnt_q : cnt_q + 1'b1;
      addr_d = last ? addr_q : cnt_q + 1'b1;
      wren_d = !last;
      done_d = last;
    end else if (clear) begin
      state_d = CLEAR;
      cnt_d = '0;
      addr_d = '0;
      data_d = clear_colour;
      wren_d = 1'b1;
    end else if (plot) begin
      addr_d = in_range ? pix_addr : addr_q;
      data_d = in_range ? colour : data_q;
      wren_d = in_range;
      oob_d = !in_range;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      wren_q <= 1'b0;
      done_q <= 1'b0;
      oob_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wren_q <= wren_d;
      done_q <= done_d;
      oob_q <= oob_d;
    end
  end
  assign mem_address = addr_q;
  assign mem_data = data_q;
  assign mem_wren = wren_q;
  assign done = done_q;
  assign oob = oob_q;
endmodule
